// File: rtl/dut_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU opcodes and error codes.
package dut_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [7:0] {
        OP_ADD = 8'd0,
        OP_SUB = 8'd1,
        OP_MUL = 8'd2,
        OP_DIV = 8'd3,
        OP_AND = 8'd4,
        OP_OR  = 8'd5,
        OP_XOR = 8'd6,
        OP_SLL = 8'd7,
        OP_SRL = 8'd8,
        OP_SRA = 8'd9,
        OP_WMR = 8'd10
    } operation_t;

    localparam logic [7:0] ERR_NONE       = 8'h00;
    localparam logic [7:0] ERR_ILLEGAL_OP = 8'hFE;
    localparam logic [7:0] ERR_TIMEOUT    = 8'hFF;

    function automatic logic op_is_legal(input logic [7:0] op);
        return op <= 8'(OP_WMR);
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin one-hot grant: first set request found searching upward from rr_ptr_i, wrapping.
module rr_grant #(
    parameter int NUM_REQ = 2,
    parameter int PW      = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    always_comb begin
        int   k;
        logic found;
        grant_o = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(rr_ptr_i) + i) % NUM_REQ;
            if (!found && req_i[k]) begin
                grant_o[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between NUM_REQ requesters with round-robin grant and a done timeout.
//  state | meaning
//  IDLE  | waiting for any req_valid; grants, pulses req_ready, latches the command
//  BUSY  | alu_start held with the latched command until alu_done or timeout
//  RESP  | one-cycle rsp_valid to the granted requester, then back to IDLE
module alu_arbiter
    import dut_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_A,
    input  logic [NUM_REQ*32-1:0] req_B,
    input  logic [NUM_REQ-1:0]    req_sv,
    input  logic [NUM_REQ-1:0]    req_op_prefix,
    input  logic [NUM_REQ*8-1:0]  req_op,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [63:0]           rsp_result,
    output logic [7:0]            rsp_err,
    output logic                  rsp_gp,
    output logic                  alu_start,
    output logic [7:0]            alu_op,
    output logic [31:0]           alu_A,
    output logic [31:0]           alu_B,
    output logic                  alu_sv,
    output logic                  alu_op_prefix,
    input  logic                  alu_done,
    input  logic [63:0]           alu_result,
    input  logic [7:0]            alu_err,
    input  logic                  alu_gp
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = ($clog2(TIMEOUT + 1) > 7) ? $clog2(TIMEOUT + 1) : 7;

    arb_state_t           state_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [PW-1:0]        gidx_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [63:0]          rsp_result_q;
    logic [7:0]           rsp_err_q;
    logic                 rsp_gp_q;
    logic                 alu_start_q;
    logic [7:0]           alu_op_q;
    logic [31:0]          alu_a_q;
    logic [31:0]          alu_b_q;
    logic                 alu_sv_q;
    logic                 alu_pfx_q;

    logic [NUM_REQ-1:0]   gnt_d;
    logic [PW-1:0]        gnt_idx_d;
    logic [31:0]          a_d;
    logic [31:0]          b_d;
    logic [7:0]           op_d;
    logic                 sv_d;
    logic                 pfx_d;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_grant (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (gnt_d)
    );

    always_comb begin
        int sel;
        gnt_idx_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_d[i]) gnt_idx_d = PW'(i);
        end
        sel   = int'(gnt_idx_d);
        a_d   = req_A[sel*32 +: 32];
        b_d   = req_B[sel*32 +: 32];
        op_d  = req_op[sel*8 +: 8];
        sv_d  = req_sv[sel];
        pfx_d = req_op_prefix[sel];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gidx_q       <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= '0;
            rsp_gp_q     <= 1'b0;
            alu_start_q  <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sv_q     <= 1'b0;
            alu_pfx_q    <= 1'b0;
        end else begin
            req_ready_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        req_ready_q <= gnt_d;
                        grant_q     <= gnt_d;
                        gidx_q      <= gnt_idx_d;
                        if (op_is_legal(op_d)) begin
                            alu_op_q  <= op_d;
                            alu_a_q   <= a_d;
                            alu_b_q   <= b_d;
                            alu_sv_q  <= sv_d;
                            alu_pfx_q <= pfx_d;
                            cnt_q     <= '0;
                            state_q   <= BUSY;
                        end else begin
                            rsp_result_q <= '0;
                            rsp_err_q    <= ERR_ILLEGAL_OP;
                            rsp_gp_q     <= 1'b0;
                            state_q      <= RESP;
                        end
                    end
                end
                BUSY: begin
                    // First BUSY cycle is the accept cycle; the command goes out from the next one.
                    if (!alu_start_q) begin
                        alu_start_q <= 1'b1;
                    end else if (alu_done || cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_result_q <= alu_done ? alu_result : 64'd0;
                        rsp_err_q    <= alu_done ? alu_err : ERR_TIMEOUT;
                        rsp_gp_q     <= alu_done ? alu_gp : 1'b0;
                        rsp_valid_q  <= grant_q;
                        alu_start_q  <= 1'b0;
                        alu_op_q     <= '0;
                        alu_a_q      <= '0;
                        alu_b_q      <= '0;
                        alu_sv_q     <= 1'b0;
                        alu_pfx_q    <= 1'b0;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    // Illegal-op path arrives with rsp_valid still low and raises it here.
                    if (rsp_valid_q == '0) begin
                        rsp_valid_q <= grant_q;
                    end else begin
                        rsp_valid_q <= '0;
                        rr_ptr_q    <= (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_gp        = rsp_gp_q;
    assign alu_start     = alu_start_q;
    assign alu_op        = alu_op_q;
    assign alu_A         = alu_a_q;
    assign alu_B         = alu_b_q;
    assign alu_sv        = alu_sv_q;
    assign alu_op_prefix = alu_pfx_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one ALU.
REQ-002 Parameter TIMEOUT, default 64, maximum cycles to wait for alu_done.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester command valid.
REQ-006 req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-007 req_A, req_B  input  NUM_REQ x 32  operands.
REQ-008 req_sv, req_op_prefix  input  NUM_REQ x 1  signed-mode and prefix qualifiers.
REQ-009 req_op  input  NUM_REQ x 8  opcode.
REQ-010 rsp_valid  output  NUM_REQ  one-cycle response pulse to the owning requester.
REQ-011 rsp_result  output  64; rsp_err  output  8; rsp_gp  output  1; shared response payload, valid only with rsp_valid.
REQ-012 alu_start  output  1; alu_op  output  8; alu_A, alu_B  output  32; alu_sv, alu_op_prefix  output  1; ALU command bus.
REQ-013 alu_done  input  1; alu_result  input  64; alu_err  input  8; alu_gp  input  1; ALU completion bus.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, RESP.
REQ-015 In IDLE with any req_valid set, the arbiter SHALL grant one requester, pulse its req_ready for one cycle, latch its A/B/sv/op_prefix/op, and go to BUSY (or RESP for an illegal op).
REQ-016 Grant SHALL be round-robin: search starts at rr_ptr; after each response rr_ptr SHALL become grant+1 modulo NUM_REQ.
REQ-017 An opcode greater than 10 (beyond _wmr) SHALL NOT be issued; the arbiter SHALL go directly to RESP with rsp_err=8'hFE, rsp_result=0, rsp_gp=0.
REQ-018 In BUSY, alu_start SHALL be 1 and the alu_* command outputs SHALL hold the latched values, stable every cycle until exit.
REQ-019 alu_done sampled high in BUSY SHALL capture alu_result/alu_err/alu_gp, drop alu_start the next cycle, and enter RESP.
REQ-020 Latency: accept at cycle N, alu_start high from N+1, alu_done at cycle M, rsp_valid at M+1.
REQ-021 A 7-bit-minimum cycle counter SHALL clear on BUSY entry; if TIMEOUT cycles elapse in BUSY without alu_done, the arbiter SHALL enter RESP with rsp_err=8'hFF, rsp_result=0, rsp_gp=0.
REQ-022 In RESP, rsp_valid SHALL pulse for exactly one cycle on the granted bit only, then the FSM SHALL return to IDLE.
REQ-023 alu_done while in IDLE or RESP SHALL be ignored.
REQ-024 req_valid changes outside IDLE SHALL have no effect; a pending request SHALL be held by its requester until req_ready.
REQ-025 At most one req_ready and one rsp_valid bit SHALL be set in any cycle.

Reset
REQ-026 reset_n low SHALL immediately force state IDLE, rr_ptr=0, counter=0, and all outputs (req_ready, rsp_*, alu_*) to 0.
REQ-027 Reset during BUSY SHALL abort the transaction with no rsp_valid; alu_start SHALL be 0 while reset_n is low.

Structure
REQ-028 The arbiter state enum and the error constants ERR_ILLEGAL_OP=8'hFE, ERR_TIMEOUT=8'hFF SHALL live in dut_pkg alongside operation_t.
REQ-029 The round-robin grant logic SHALL be a sub-module rr_grant (inputs req vector, rr_ptr; output one-hot grant).

Verification
REQ-030 Single requester 0: add A=5, B=7; ALU done after 3 cycles with result 12 -> req_ready[0] one pulse, alu_start high 3 cycles, rsp_valid[0] with rsp_result=12, rsp_err=0.
REQ-031 Both requesters valid from reset (xor, mul) -> requester 0 served first, requester 1 second; then both valid again -> requester 0 served (pointer wraps).
REQ-032 Requester 1 op=8'd11 -> no alu_start, rsp_valid[1] next cycle with rsp_err=8'hFE.
REQ-033 ALU never asserts done, TIMEOUT=64 -> alu_start high exactly 64 cycles, then rsp_valid with rsp_err=8'hFF, result 0.
REQ-034 reset_n pulsed low mid-BUSY -> alu_start and all outputs 0 asynchronously, no rsp_valid; next request after release is granted to requester 0.
REQ-035 Spurious alu_done in IDLE -> no rsp_valid, state remains IDLE.
